vs_elastic_pipe: RTL and testbench

//  Parametrised multi-stage pipeline register with valid/ready flow control, synchronous flush
//  and an occupancy count. Replaces chains of plain/enabled D flops between vertex_shader units
//  (fetch -> transform -> clip) where stalls must back-pressure upstream without losing data.

---
 rtl/vs_elastic_pipe_pkg.sv | 15 +
 rtl/vs_pipe_slot.sv | 48 ++++
 rtl/vs_elastic_pipe.sv | 109 ++++++++++
 tb/tb_vs_elastic_pipe.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vs_elastic_pipe_pkg.sv
// Shared defaults and helpers for the vertex_shader elastic pipeline.
//   VS_DATA_WIDTH  : default payload width between vertex_shader units
//   VS_PIPE_STAGES : default number of register stages in an elastic pipe
//   occ_width()    : width of an occupancy counter that can hold 0..stages
package vs_elastic_pipe_pkg;

    localparam int unsigned VS_DATA_WIDTH  = 32;
    localparam int unsigned VS_PIPE_STAGES = 2;

    // Bits needed to count 0..stages inclusive.
    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/vs_pipe_slot.sv
// One elastic pipeline stage: a valid bit and a payload register.
//   clk, resetn : clock, async active-low reset
//   flush_i     : synchronous discard of the held entry
//   adv_i       : stage may take the upstream entry this cycle
//   v_i, d_i    : upstream valid / payload
//   v_o, d_o    : registered valid / payload held by this stage
module vs_pipe_slot
    import vs_elastic_pipe_pkg::*;
#(
    parameter int unsigned DW = VS_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush_i,
    input  logic          adv_i,
    input  logic          v_i,
    input  logic [DW-1:0] d_i,
    output logic          v_o,
    output logic [DW-1:0] d_o
);

    logic          v_q;
    logic [DW-1:0] d_q;

    // Valid follows upstream whenever the stage advances; flush wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q <= 1'b0;
        end else if (flush_i) begin
            v_q <= 1'b0;
        end else if (adv_i) begin
            v_q <= v_i;
        end
    end

    // Payload only loads with a valid entry, so bubbles leave the old data in place.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_q <= '0;
        end else if (adv_i && v_i) begin
            d_q <= d_i;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/vs_elastic_pipe.sv
// Multi-stage valid/ready pipeline register with bubble collapsing,
// synchronous flush and an occupancy count.
//   clk, resetn          : clock, async active-low reset
//   flush                : discard all held entries at the next edge
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload (last stage)
//   occupancy            : number of valid stages, 0..STAGES
module vs_elastic_pipe
    import vs_elastic_pipe_pkg::*;
#(
    parameter int unsigned DW     = VS_DATA_WIDTH,
    parameter int unsigned STAGES = VS_PIPE_STAGES,
    parameter int unsigned CW     = occ_width(STAGES)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] occupancy
);

    logic [STAGES-1:0] stage_v;
    logic [DW-1:0]     stage_d [STAGES];
    logic [STAGES-1:0] adv_c;
    logic              xfer_in_c;
    logic              xfer_out_c;
    logic [CW-1:0]     occ_q;
    logic [CW-1:0]     occ_d;

    // Ready chain from the output backwards: a stage advances if it is empty
    // or the stage ahead of it advances, so holes are filled even under stall.
    always_comb begin
        adv_c = '0;
        adv_c[STAGES-1] = out_ready | ~stage_v[STAGES-1];
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            adv_c[i] = adv_c[i+1] | ~stage_v[i];
        end
    end

    assign in_ready   = adv_c[0] & ~flush;
    assign xfer_in_c  = in_valid & in_ready;
    assign xfer_out_c = out_valid & out_ready;

    // Stage chain: stage 0 takes accepted upstream entries, stage g takes stage g-1.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic          v_in;
        logic [DW-1:0] d_in;

        if (g == 0) begin : g_head
            assign v_in = xfer_in_c;
            assign d_in = in_data;
        end else begin : g_body
            assign v_in = stage_v[g-1];
            assign d_in = stage_d[g-1];
        end

        vs_pipe_slot #(
            .DW (DW)
        ) u_slot (
            .clk     (clk),
            .resetn  (resetn),
            .flush_i (flush),
            .adv_i   (adv_c[g]),
            .v_i     (v_in),
            .d_i     (d_in),
            .v_o     (stage_v[g]),
            .d_o     (stage_d[g])
        );
    end

    assign out_valid = stage_v[STAGES-1];
    assign out_data  = stage_d[STAGES-1];

    // Occupancy tracks accepted minus delivered; flush empties the pipe.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + CW'(xfer_in_c) - CW'(xfer_out_c);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

`ifndef SYNTHESIS
    // Counter can never claim more entries than there are stages.
    a_occ_bound : assert property (@(posedge clk) disable iff (!resetn)
        occ_q <= CW'(STAGES));

    // A stalled head entry stays put with its payload unchanged.
    a_stall_hold : assert property (@(posedge clk) disable iff (!resetn)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
`endif

endmodule

// File: tb/tb_vs_elastic_pipe.sv
module tb_vs_elastic_pipe;

    logic       clk;
    logic       resetn;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready3, out_valid3;
    logic [7:0] out_data3;
    logic [1:0] occ3;
    logic       in_ready1, out_valid1;
    logic [7:0] out_data1;
    logic [0:0] occ1;

    int n_checks = 0;
    int n_fail   = 0;

    vs_elastic_pipe #(.DW(8), .STAGES(3)) u3 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .occupancy(occ3)
    );

    vs_elastic_pipe #(.DW(8), .STAGES(1)) u1 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO of accepted entries with the edge at which each was
    // accepted. The head is visible once it has spent STAGES-1 edges in the pipe
    // and the previous head has left.
    typedef struct {
        logic [7:0] data;
        int         acc;
    } ent_t;

    ent_t q3[$];
    ent_t q1[$];
    int   edge_n = 0;
    int   dep3 = 0;
    int   dep1 = 0;

    logic       e3_v, e3_r, e1_v, e1_r;
    logic [7:0] e3_d, e1_d;
    int         e3_o, e1_o;
    logic       x3_in, x3_out, x1_in, x1_out;

    task automatic predict();
        int vis;
        e3_o = q3.size();
        e3_r = ((q3.size() < 3) || out_ready) && !flush;
        e3_v = 1'b0;
        e3_d = 8'h00;
        if (q3.size() > 0) begin
            vis = q3[0].acc + 2;
            if (dep3 > vis) vis = dep3;
            e3_v = (edge_n >= vis);
            e3_d = q3[0].data;
        end
        x3_in  = in_valid && e3_r;
        x3_out = e3_v && out_ready;

        e1_o = q1.size();
        e1_r = ((q1.size() < 1) || out_ready) && !flush;
        e1_v = 1'b0;
        e1_d = 8'h00;
        if (q1.size() > 0) begin
            vis = q1[0].acc;
            if (dep1 > vis) vis = dep1;
            e1_v = (edge_n >= vis);
            e1_d = q1[0].data;
        end
        x1_in  = in_valid && e1_r;
        x1_out = e1_v && out_ready;
    endtask

    task automatic advance();
        edge_n++;
        if (flush) begin
            q3.delete();
            q1.delete();
        end else begin
            if (x3_out) begin void'(q3.pop_front()); dep3 = edge_n; end
            if (x3_in)  q3.push_back('{in_data, edge_n});
            if (x1_out) begin void'(q1.pop_front()); dep1 = edge_n; end
            if (x1_in)  q1.push_back('{in_data, edge_n});
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        advance();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        resetn = 1'b0;
        q3.delete();
        q1.delete();
        repeat (2) begin @(posedge clk); edge_n++; end
        @(negedge clk);
        resetn = 1'b1;
        dep3 = edge_n;
        dep1 = edge_n;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if ({out_valid3, out_data3, occ3, in_ready3} !== {1'b0, 8'h00, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_init_s3: got v=%b d=%h occ=%0d rdy=%b, want v=0 d=00 occ=0 rdy=1",
                     out_valid3, out_data3, occ3, in_ready3);
        end
        n_checks++;
        if ({out_valid1, out_data1, occ1, in_ready1} !== {1'b0, 8'h00, 1'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_init_s1: got v=%b d=%h occ=%0d rdy=%b, want v=0 d=00 occ=0 rdy=1",
                     out_valid1, out_data1, occ1, in_ready1);
        end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 8'(16 + c), 1'b0, 1'b0);
            n_checks++;
            if ({out_valid3, in_ready3, occ3} !== {e3_v, e3_r, 2'(e3_o)}) begin
                n_fail++;
                $display("FAIL reset_traffic_ctl c=%0d: got v/r/occ %b/%b/%0d want %b/%b/%0d",
                         c, out_valid3, in_ready3, occ3, e3_v, e3_r, e3_o);
            end
            tick();
        end
        #3;
        resetn = 1'b0;
        q3.delete();
        q1.delete();
        #1;
        n_checks++;
        if ({out_valid3, out_data3, occ3, out_valid1, out_data1, occ1} !== '0) begin
            n_fail++;
            $display("FAIL reset_midtraffic: got s3 v=%b d=%h occ=%0d s1 v=%b d=%h occ=%0d, want all 0",
                     out_valid3, out_data3, occ3, out_valid1, out_data1, occ1);
        end
        in_valid = 1'b0;
        @(posedge clk); edge_n++;
        @(negedge clk);
        resetn = 1'b1;
        dep3 = edge_n;
        dep1 = edge_n;
        #1;
        n_checks++;
        if ({in_ready3, in_ready1} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b%b want 11", in_ready3, in_ready1);
        end
    endtask

    task automatic test_stream();
        int first_acc = -1;
        int k = 0;
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            drive(c < 8, 8'(c + 1), 1'b1, 1'b0);
            n_checks++;
            if ({out_valid3, in_ready3, occ3} !== {e3_v, e3_r, 2'(e3_o)}) begin
                n_fail++;
                $display("FAIL stream_ctl c=%0d: got v/r/occ %b/%b/%0d want %b/%b/%0d",
                         c, out_valid3, in_ready3, occ3, e3_v, e3_r, e3_o);
            end
            if (out_valid3) begin
                n_checks++;
                if (out_data3 !== 8'(k + 1) || edge_n != first_acc + 2 + k) begin
                    n_fail++;
                    $display("FAIL stream_order k=%0d: got data %h at edge %0d want %h at edge %0d",
                             k, out_data3, edge_n, 8'(k + 1), first_acc + 2 + k);
                end
                k++;
            end
            if (x3_in && first_acc < 0) first_acc = edge_n + 1;
            tick();
        end
        n_checks++;
        if (k != 8) begin
            n_fail++;
            $display("FAIL stream_count: got %0d outputs want 8", k);
        end
    endtask

    task automatic test_back_pressure();
        int k = 0;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, (c < 3) ? 8'(8'hA1 + c) : 8'hFF, 1'b0, 1'b0);
            n_checks++;
            if ({out_valid3, in_ready3, occ3} !== {e3_v, e3_r, 2'(e3_o)}) begin
                n_fail++;
                $display("FAIL bp_fill_ctl c=%0d: got v/r/occ %b/%b/%0d want %b/%b/%0d",
                         c, out_valid3, in_ready3, occ3, e3_v, e3_r, e3_o);
            end
            tick();
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        n_checks++;
        if ({occ3, in_ready3, out_valid3, out_data3} !== {2'd3, 1'b0, 1'b1, 8'hA1}) begin
            n_fail++;
            $display("FAIL bp_full: got occ=%0d rdy=%b v=%b d=%h want occ=3 rdy=0 v=1 d=a1",
                     occ3, in_ready3, out_valid3, out_data3);
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if ({out_valid3, in_ready3, occ3} !== {e3_v, e3_r, 2'(e3_o)}) begin
                n_fail++;
                $display("FAIL bp_drain_ctl c=%0d: got v/r/occ %b/%b/%0d want %b/%b/%0d",
                         c, out_valid3, in_ready3, occ3, e3_v, e3_r, e3_o);
            end
            if (out_valid3) begin
                n_checks++;
                if (out_data3 !== 8'(8'hA1 + k)) begin
                    n_fail++;
                    $display("FAIL bp_drain_data k=%0d: got %h want %h", k, out_data3, 8'(8'hA1 + k));
                end
                k++;
            end
            tick();
        end
        n_checks++;
        if (k != 3) begin
            n_fail++;
            $display("FAIL bp_drain_count: got %0d want 3", k);
        end
    endtask

    task automatic test_bubble_collapse();
        logic       ivs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] ds  [5] = '{8'hB1, 8'h00, 8'hB2, 8'h00, 8'h00};
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            drive(ivs[c], ds[c], 1'b0, 1'b0);
            n_checks++;
            if ({out_valid3, in_ready3, occ3} !== {e3_v, e3_r, 2'(e3_o)}) begin
                n_fail++;
                $display("FAIL bubble_ctl c=%0d: got v/r/occ %b/%b/%0d want %b/%b/%0d",
                         c, out_valid3, in_ready3, occ3, e3_v, e3_r, e3_o);
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({occ3, in_ready3, out_valid3, out_data3} !== {2'd2, 1'b1, 1'b1, 8'hB1}) begin
            n_fail++;
            $display("FAIL bubble_held: got occ=%0d rdy=%b v=%b d=%h want occ=2 rdy=1 v=1 d=b1",
                     occ3, in_ready3, out_valid3, out_data3);
        end
        tick();
    endtask

    task automatic test_flush();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            drive(c < 2, (c == 0) ? 8'hC1 : 8'hC2, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        n_checks++;
        if ({in_ready3, out_valid3, out_data3, occ3} !== {1'b0, 1'b1, 8'hC1, 2'd2}) begin
            n_fail++;
            $display("FAIL flush_cycle: got rdy=%b v=%b d=%h occ=%0d want rdy=0 v=1 d=c1 occ=2",
                     in_ready3, out_valid3, out_data3, occ3);
        end
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({out_valid3, occ3} !== {1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL flush_after: got v=%b occ=%0d want v=0 occ=0", out_valid3, occ3);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 8'hD1, 1'b1, 1'b0);
            n_checks++;
            if ({out_valid3, in_ready3, occ3} !== {e3_v, e3_r, 2'(e3_o)}) begin
                n_fail++;
                $display("FAIL flush_recover_ctl c=%0d: got v/r/occ %b/%b/%0d want %b/%b/%0d",
                         c, out_valid3, in_ready3, occ3, e3_v, e3_r, e3_o);
            end
            if (e3_v) begin
                n_checks++;
                if (out_data3 !== e3_d) begin
                    n_fail++;
                    $display("FAIL flush_recover_data c=%0d: got %h want %h", c, out_data3, e3_d);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_stage();
        logic [7:0] prev = 8'h00;
        logic [7:0] d;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            d = 8'($urandom);
            drive(1'b1, d, 1'b1, 1'b0);
            n_checks++;
            if ({out_valid1, in_ready1, occ1} !== {e1_v, e1_r, 1'(e1_o)}) begin
                n_fail++;
                $display("FAIL s1_ctl c=%0d: got v/r/occ %b/%b/%0d want %b/%b/%0d",
                         c, out_valid1, in_ready1, occ1, e1_v, e1_r, e1_o);
            end
            if (c > 0) begin
                n_checks++;
                if ({in_ready1, occ1, out_valid1, out_data1} !== {1'b1, 1'b1, 1'b1, prev}) begin
                    n_fail++;
                    $display("FAIL s1_throughput c=%0d: got rdy=%b occ=%0d v=%b d=%h want 1/1/1/%h",
                             c, in_ready1, occ1, out_valid1, out_data1, prev);
                end
            end
            prev = d;
            tick();
        end
    endtask

    task automatic test_random();
        int pct;
        apply_reset();
        for (int c = 0; c < 500; c++) begin
            pct = (c < 250) ? 40 : 85;
            drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 100) < pct, ($urandom % 20) == 0);
            n_checks++;
            if ({out_valid3, in_ready3, occ3} !== {e3_v, e3_r, 2'(e3_o)}) begin
                n_fail++;
                $display("FAIL rand_s3_ctl c=%0d: got v/r/occ %b/%b/%0d want %b/%b/%0d",
                         c, out_valid3, in_ready3, occ3, e3_v, e3_r, e3_o);
            end
            if (e3_v) begin
                n_checks++;
                if (out_data3 !== e3_d) begin
                    n_fail++;
                    $display("FAIL rand_s3_data c=%0d: got %h want %h", c, out_data3, e3_d);
                end
            end
            n_checks++;
            if ({out_valid1, in_ready1, occ1} !== {e1_v, e1_r, 1'(e1_o)}) begin
                n_fail++;
                $display("FAIL rand_s1_ctl c=%0d: got v/r/occ %b/%b/%0d want %b/%b/%0d",
                         c, out_valid1, in_ready1, occ1, e1_v, e1_r, e1_o);
            end
            if (e1_v) begin
                n_checks++;
                if (out_data1 !== e1_d) begin
                    n_fail++;
                    $display("FAIL rand_s1_data c=%0d: got %h want %h", c, out_data1, e1_d);
                end
            end
            tick();
        end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_bubble_collapse();
        test_flush();
        test_single_stage();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
